// File: rtl/sq_mul_pkg.sv
// Shared constants for the Sq cyclic-convolution sequencer: FSM encoding,
// ternary r-coefficient codes and default ring dimensions.
package sq_mul_pkg;

    localparam int SQ_N                = 701;
    localparam int SQ_LOG_N            = 10;
    localparam int SQ_NUM_WIDTH_LENGTH = 13;

    typedef logic [2:0] sq_state_t;

    localparam sq_state_t ST_IDLE  = 3'd0;
    localparam sq_state_t ST_CLEAR = 3'd1;
    localparam sq_state_t ST_FETCH = 3'd2;
    localparam sq_state_t ST_WAIT  = 3'd3;
    localparam sq_state_t ST_MAC   = 3'd4;
    localparam sq_state_t ST_DRAIN = 3'd5;
    localparam sq_state_t ST_DONE  = 3'd6;

    localparam logic [1:0] COEF_ZERO = 2'b00;
    localparam logic [1:0] COEF_POS  = 2'b01;
    localparam logic [1:0] COEF_NEG  = 2'b11;

    // Code 2'b10 is not a legal ternary value and is treated as zero.
    function automatic logic coef_is_nz(input logic [1:0] c);
        case (c)
            COEF_POS, COEF_NEG: return 1'b1;
            COEF_ZERO:          return 1'b0;
            default:            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sq_mul_ctrl_mod_n_counter.sv
// Modulo-N up-counter with synchronous clear and load; wrap flags the
// terminal count N-1 so the next increment returns to zero.
module mod_n_counter #(
    parameter int N = 701,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = (count == W'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sq_mul_ctrl.sv
// Sequencer for c = h*r mod (x^N - 1) over an external add/sub datapath.
// Build option SQ_MUL_SKIP_ZERO_EN skips MAC for zero r rows (data-dependent timing).
module sq_mul_ctrl
    import sq_mul_pkg::*;
#(
    parameter int N     = SQ_N,
    parameter int LOG_N = SQ_LOG_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             r_rd_en,
    output logic [LOG_N-1:0] r_addr,
    input  logic [1:0]       r_coef,
    output logic [LOG_N-1:0] h_addr,
    output logic [LOG_N-1:0] acc_rd_addr,
    output logic [LOG_N-1:0] acc_wr_addr,
    output logic             acc_we,
    output logic             acc_clr,
    output logic             sub
);

    sq_state_t        state_q, state_d;
    logic [LOG_N-1:0] i_cnt, j_cnt, k_cnt, k_init;
    logic             i_wrap, j_wrap, k_wrap_unused;
    logic             accept, mac_end, row_skip;
    logic             coef_nz_q, coef_neg_q;
    logic             we_p1;
    logic [LOG_N-1:0] wr_addr_p1;

    assign accept  = (state_q == ST_IDLE) && start;
    assign mac_end = (state_q == ST_MAC) && j_wrap;
    // Row i reads h starting at (N - i) mod N so that h_addr = (j - i) mod N.
    assign k_init  = (i_cnt == '0) ? '0 : LOG_N'(N) - i_cnt;

`ifdef SQ_MUL_SKIP_ZERO_EN
    assign row_skip = (state_q == ST_WAIT) && !coef_is_nz(r_coef);
`else
    assign row_skip = 1'b0;
`endif

    mod_n_counter #(.N(N), .W(LOG_N)) u_i_cnt (
        .clk(clk), .rst(rst),
        .clr(accept), .load(1'b0), .load_val('0),
        .inc((mac_end || row_skip) && !i_wrap),
        .count(i_cnt), .wrap(i_wrap)
    );

    mod_n_counter #(.N(N), .W(LOG_N)) u_j_cnt (
        .clk(clk), .rst(rst),
        .clr(accept || (state_q == ST_WAIT)), .load(1'b0), .load_val('0),
        .inc((state_q == ST_CLEAR) || (state_q == ST_MAC)),
        .count(j_cnt), .wrap(j_wrap)
    );

    mod_n_counter #(.N(N), .W(LOG_N)) u_k_cnt (
        .clk(clk), .rst(rst),
        .clr(1'b0), .load(state_q == ST_WAIT), .load_val(k_init),
        .inc(state_q == ST_MAC),
        .count(k_cnt), .wrap(k_wrap_unused)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CLEAR;
            ST_CLEAR: if (j_wrap) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  begin
                if (row_skip) state_d = i_wrap ? ST_DRAIN : ST_FETCH;
                else          state_d = ST_MAC;
            end
            ST_MAC:   if (j_wrap) state_d = i_wrap ? ST_DRAIN : ST_FETCH;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            coef_nz_q  <= 1'b0;
            coef_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_WAIT) begin
                coef_nz_q  <= coef_is_nz(r_coef);
                coef_neg_q <= (r_coef == COEF_NEG);
            end
        end
    end

    // ---- p1: accumulator write lags the MAC read by one cycle ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_p1      <= 1'b0;
            wr_addr_p1 <= '0;
        end else begin
            we_p1      <= (state_q == ST_MAC) && coef_nz_q;
            wr_addr_p1 <= j_cnt;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign r_rd_en     = (state_q == ST_FETCH);
    assign r_addr      = i_cnt;
    assign h_addr      = k_cnt;
    assign acc_rd_addr = j_cnt;
    assign acc_clr     = (state_q == ST_CLEAR);
    assign acc_we      = acc_clr || we_p1;
    assign acc_wr_addr = acc_clr ? j_cnt : wr_addr_p1;
    // Sign stays latched through the trailing write cycle of the row.
    assign sub         = coef_neg_q;

endmodule

// File: tb/tb_sq_mul_ctrl.sv
// Scoreboard bench for sq_mul_ctrl at N=5 with behavioural r/h/acc memories
// and the 13-bit add/sub datapath.
module tb_sq_mul_ctrl;
    import sq_mul_pkg::*;

    localparam int N     = 5;
    localparam int LOG_N = 3;
    localparam int W     = SQ_NUM_WIDTH_LENGTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy, done, r_rd_en, acc_we, acc_clr, sub;
    logic [LOG_N-1:0] r_addr, h_addr, acc_rd_addr, acc_wr_addr;
    logic [1:0]       r_coef;

    sq_mul_ctrl #(.N(N), .LOG_N(LOG_N)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .r_rd_en(r_rd_en), .r_addr(r_addr), .r_coef(r_coef), .h_addr(h_addr),
        .acc_rd_addr(acc_rd_addr), .acc_wr_addr(acc_wr_addr),
        .acc_we(acc_we), .acc_clr(acc_clr), .sub(sub)
    );

    always #5 clk = ~clk;

    logic [1:0]   r_mem [N];
    logic [W-1:0] h_mem [N];
    logic [W-1:0] acc_mem [N];
    logic [1:0]   r_q = 2'b00;
    logic [W-1:0] aq = '0;
    logic [W-1:0] hq = '0;

    assign r_coef = r_q;

    always @(posedge clk) begin
        if (r_rd_en) r_q <= r_mem[r_addr];
        aq <= acc_mem[acc_rd_addr];
        hq <= h_mem[h_addr];
        if (acc_we) acc_mem[acc_wr_addr] <= acc_clr ? '0 : aq + (sub ? ~hq : hq) + W'(sub);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int outs();
        return int'({busy, done, r_rd_en, acc_we, acc_clr, sub,
                     r_addr, h_addr, acc_rd_addr, acc_wr_addr});
    endfunction

    int           rv [N];
    int           hv [N];
    int           sb_lat[$];
    logic [W-1:0] sb_acc[$];
    int           sb_h[$];
    int           sb_sub[$];

    function automatic logic [1:0] enc(input int v);
        if (v == 1)  return 2'b01;
        if (v == -1) return 2'b11;
        if (v == 2)  return 2'b10;
        return 2'b00;
    endfunction

    function automatic int sval(input int v);
        return (v == 1 || v == -1) ? v : 0;
    endfunction

    // Load memories and push the expected product, latency and write trace.
    task automatic load_job();
        int lat;
        for (int i = 0; i < N; i++) begin
            r_mem[i] = enc(rv[i]);
            h_mem[i] = W'(hv[i]);
        end
`ifdef SQ_MUL_SKIP_ZERO_EN
        lat = N + 2;
        for (int i = 0; i < N; i++) lat += (sval(rv[i]) != 0) ? N + 2 : 2;
`else
        lat = N * N + 3 * N + 2;
`endif
        sb_lat.push_back(lat);
        for (int j = 0; j < N; j++) begin
            int s;
            s = 0;
            for (int i = 0; i < N; i++) s += sval(rv[i]) * hv[(j - i + N) % N];
            sb_acc.push_back(W'(s));
        end
        for (int i = 0; i < N; i++) begin
            if (sval(rv[i]) != 0) begin
                for (int j = 0; j < N; j++) begin
                    sb_h.push_back((j - i + N) % N);
                    sb_sub.push_back((rv[i] == -1) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic run_job(input int poke_at, input int rst_at);
        int n, busy_bad, prev_h, exp_lat, m;
        bit aborted;
        int clr_q[$];
        int gh[$];
        int gs[$];
        busy_bad = 0;
        prev_h   = 0;
        aborted  = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (n = 1; n <= 400; n++) begin
            @(negedge clk);
            start = (n == poke_at);
            if (n == rst_at) begin
                rst = 1'b0;
                #1;
                chk("rst_mid_outputs", outs(), 0);
                aborted = 1;
                break;
            end
            if (!busy) busy_bad++;
            if (acc_we && acc_clr) clr_q.push_back(int'(acc_wr_addr));
            if (acc_we && !acc_clr) begin
                gh.push_back(prev_h);
                gs.push_back(int'(sub));
            end
            prev_h = int'(h_addr);
            if (done) break;
        end
        if (aborted) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_hold_outputs", outs(), 0);
            rst = 1'b1;
            void'(sb_lat.pop_front());
            repeat (N) void'(sb_acc.pop_front());
            sb_h.delete();
            sb_sub.delete();
            return;
        end
        exp_lat = sb_lat.pop_front();
        chk("done_latency", n, exp_lat);
        chk("busy_gaps", busy_bad, 0);
        chk("clear_count", clr_q.size(), N);
        for (int a = 0; a < clr_q.size() && a < N; a++) chk("clear_addr", clr_q[a], a);
        chk("mac_write_count", gh.size(), sb_h.size());
        m = (gh.size() < sb_h.size()) ? gh.size() : sb_h.size();
        for (int a = 0; a < m; a++) begin
            chk("mac_h_addr", gh[a], sb_h[a]);
            chk("mac_sub", gs[a], sb_sub[a]);
        end
        sb_h.delete();
        sb_sub.delete();
        @(negedge clk);
        chk("done_pulse_end", int'({done, busy}), 0);
        for (int j = 0; j < N; j++) chk("acc_value", int'(acc_mem[j]), int'(sb_acc.pop_front()));
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            r_mem[i]   = 2'b00;
            h_mem[i]   = '0;
            acc_mem[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outputs", outs(), 0);

        rv = '{0, 0, 0, 0, 0};       hv = '{1, 2, 3, 4, 5};
        load_job(); run_job(-1, -1);

        rv = '{1, 0, 0, 0, 0};       hv = '{1, 2, 3, 4, 5};
        load_job(); run_job(-1, -1);

        rv = '{0, -1, 0, 0, 0};      hv = '{1, 2, 3, 4, 5};
        load_job(); run_job(-1, -1);

        // Wraparound data, illegal code 2'b10 as zero, and a stray start mid-run.
        rv = '{1, -1, 2, 1, -1};     hv = '{8191, 100, 4096, 7, 0};
        load_job(); run_job(10, -1);

        rv = '{1, 0, 0, 0, 0};       hv = '{1, 2, 3, 4, 5};
        load_job(); run_job(-1, 20);

        rv = '{-1, 1, 1, 0, -1};
        for (int i = 0; i < N; i++) hv[i] = int'($urandom_range(0, 8191));
        load_job(); run_job(-1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
